// File: rtl/wb_uart_tx_if.sv
// wb_uart_tx_if
// Purpose : Wishbone-style single-byte write channel feeding the UART
//           transmitter.
// Signals : i_wb_cyc   - bus cycle, high whenever i_wb_stb is high
//           i_wb_stb   - strobe, one byte write request
//           i_wb_data  - byte to transmit
//           o_wb_ack   - one-cycle acknowledge, the cycle after acceptance
//           o_wb_stall - write not accepted this cycle
// Modports: master drives cyc/stb/data, slave (the UART) drives ack/stall.
interface wb_uart_tx_if;
  logic       i_wb_cyc;
  logic       i_wb_stb;
  logic [7:0] i_wb_data;
  logic       o_wb_ack;
  logic       o_wb_stall;

  modport master (
    output i_wb_cyc,
    output i_wb_stb,
    output i_wb_data,
    input  o_wb_ack,
    input  o_wb_stall
  );

  modport slave (
    input  i_wb_cyc,
    input  i_wb_stb,
    input  i_wb_data,
    output o_wb_ack,
    output o_wb_stall
  );
endinterface

// File: rtl/wb_uart_tx.sv
// wb_uart_tx
// Purpose : 8N1 UART transmitter with a 2^FIFO_AW byte transmit FIFO,
//           loaded one byte per accepted write over a Wishbone-style
//           channel. Bits are LSB first, BAUD_DIV_RATE clocks per bit.
// Ports   : i_clk      - clock
//           i_reset_n  - synchronous, active-low reset
//           wb         - write channel (slave modport of wb_uart_tx_if)
//           uart_tx    - registered serial line, idle high
//           uart_busy  - frame in progress or FIFO non-empty
//           uart_full  - FIFO cannot accept a write this cycle
module wb_uart_tx #(
  parameter int                  BAUD_DIV_WIDTH = 12,
  parameter logic [BAUD_DIV_WIDTH-1:0] BAUD_DIV_RATE  = 12'd2604,
  parameter int                  FIFO_AW        = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  wb_uart_tx_if.slave   wb,
  output logic          uart_tx,
  output logic          uart_busy,
  output logic          uart_full
);

  localparam int                        LP_DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]          LP_CNT_FULL  = LP_DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]          LP_CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [BAUD_DIV_WIDTH-1:0] LP_BAUD_LAST = BAUD_DIV_RATE - BAUD_DIV_WIDTH'(1);
  localparam logic [BAUD_DIV_WIDTH-1:0] LP_BAUD_ONE  = BAUD_DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_stateNext;
  logic [7:0]                r_fifo [LP_DEPTH];
  logic [FIFO_AW-1:0]        r_wrPtr;
  logic [FIFO_AW-1:0]        r_rdPtr;
  logic [FIFO_AW:0]          r_count;
  logic [BAUD_DIV_WIDTH-1:0] r_baud;
  logic [BAUD_DIV_WIDTH-1:0] w_baudNext;
  logic [2:0]                r_bitIdx;
  logic [2:0]                w_bitIdxNext;
  logic [7:0]                r_shift;
  logic [7:0]                w_shiftNext;
  logic                      r_tx;
  logic                      w_txNext;
  logic                      r_ack;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_bitEnd;

  assign w_empty  = (r_count == '0);
  assign w_pop    = (r_state == S_LOAD);
  // The LOAD pop frees a slot in the same cycle, so a write arriving while
  // the FIFO holds 2^FIFO_AW bytes is still taken during LOAD.
  assign w_full   = (r_count == LP_CNT_FULL) && !w_pop;
  assign w_push   = wb.i_wb_cyc && wb.i_wb_stb && !w_full;
  assign w_bitEnd = (r_baud == LP_BAUD_LAST);

  assign wb.o_wb_stall = w_full;
  assign wb.o_wb_ack   = r_ack;
  assign uart_full     = w_full;
  assign uart_tx       = r_tx;
  assign uart_busy     = !((r_state == S_IDLE) && w_empty);

  // FIFO storage needs no reset; validity is tracked by the count.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_push) begin
      r_fifo[r_wrPtr] <= wb.i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_push;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_baud   <= w_baudNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
    end
  end

  // The line level is derived from the next state and next shift value so
  // that the registered uart_tx changes exactly on the state/bit boundary.
  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = r_baud + LP_BAUD_ONE;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_txNext     = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_baudNext = '0;
        if (!w_empty) w_stateNext = S_LOAD;
      end
      S_LOAD: begin
        w_baudNext   = '0;
        w_shiftNext  = r_fifo[r_rdPtr];
        w_bitIdxNext = '0;
        w_stateNext  = S_START;
      end
      S_START: begin
        if (w_bitEnd) begin
          w_baudNext  = '0;
          w_stateNext = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          w_baudNext   = '0;
          w_shiftNext  = {1'b0, r_shift[7:1]};
          w_bitIdxNext = r_bitIdx + 3'd1;
          if (r_bitIdx == 3'd7) w_stateNext = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bitEnd) begin
          w_baudNext  = '0;
          w_stateNext = w_empty ? S_IDLE : S_LOAD;
        end
      end
      default: begin
        w_baudNext  = '0;
        w_stateNext = S_IDLE;
      end
    endcase

    case (w_stateNext)
      S_START: w_txNext = 1'b0;
      S_DATA:  w_txNext = w_shiftNext[0];
      default: w_txNext = 1'b1;
    endcase
  end

endmodule
